// File: rtl/md_bus_pkg.sv
// Shared definitions for the Mega Drive 68k bus models.
//   VA_W / VD_W   : 68k word-address and data bus widths
//   BE_*          : byte-enable encodings ([1] = upper byte, [0] = lower byte)
//   bus_state_e   : responder FSM states
//   window_hit()  : masked address-window compare
package md_bus_pkg;

    localparam int VA_W = 23;
    localparam int VD_W = 16;

    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_LOWER = 2'b01;
    localparam logic [1:0] BE_WORD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DRAIN = 3'd4
    } bus_state_e;

    // Only address bits selected by mask take part in the decode.
    function automatic logic window_hit(input logic [VA_W-1:0] va,
                                        input logic [VA_W-1:0] base,
                                        input logic [VA_W-1:0] mask);
        return (va & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/md_sync2.sv
// Two-flop synchronizer for active-low strobes.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops reset to 1 (strobe inactive)
//   d     : asynchronous input
//   q     : synchronized output
module md_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus target: decodes a strobed cycle inside an address window, hands it
// to a req/ack memory backend, counts wait states, then drives DTACK and read data.
//   MCLK, n_RES          : clock, asynchronous active-low reset
//   n_AS_i/n_UDS_i/n_LDS_i, RW_i, VA_i, VD_i : 68k bus inputs
//   VD_o, VD_d           : read data and its output enable
//   n_DTACK_d            : 0 = pull DTACK low
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : backend request (held until mem_ack)
//   mem_rdata, mem_ack   : backend completion (one-cycle ack pulse)
//   busy                 : FSM not idle
//
// Handshake: mem_req rises with the latched command and stays high until the
// cycle in which mem_ack is sampled high; the command fields are stable for
// that whole interval. mem_ack while no request is pending is ignored.
module m68k_bus_responder
    import md_bus_pkg::*;
#(
    parameter logic [VA_W-1:0] BASE        = 23'h000000,
    parameter logic [VA_W-1:0] MASK        = 23'h7F0000,
    parameter int unsigned     WAIT_STATES = 2
) (
    input  logic            MCLK,
    input  logic            n_RES,
    input  logic            n_AS_i,
    input  logic            n_UDS_i,
    input  logic            n_LDS_i,
    input  logic            RW_i,
    input  logic [VA_W-1:0] VA_i,
    input  logic [VD_W-1:0] VD_i,
    output logic [VD_W-1:0] VD_o,
    output logic            VD_d,
    output logic            n_DTACK_d,
    output logic            mem_req,
    output logic            mem_we,
    output logic [VA_W-1:0] mem_addr,
    output logic [1:0]      mem_be,
    output logic [VD_W-1:0] mem_wdata,
    input  logic [VD_W-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic       n_as_q, n_uds_q, n_lds_q;
    logic       as_s, uds_s, lds_s;
    logic       start;
    logic       lost;        // AS dropped while the backend was still working
    logic [3:0] wait_cnt;
    bus_state_e state;

    md_sync2 u_sync_as  (.clk(MCLK), .rst_n(n_RES), .d(n_AS_i),  .q(n_as_q));
    md_sync2 u_sync_uds (.clk(MCLK), .rst_n(n_RES), .d(n_UDS_i), .q(n_uds_q));
    md_sync2 u_sync_lds (.clk(MCLK), .rst_n(n_RES), .d(n_LDS_i), .q(n_lds_q));

    assign as_s  = ~n_as_q;
    assign uds_s = ~n_uds_q;
    assign lds_s = ~n_lds_q;

    // Waiting for a data strobe as well as AS covers writes, where DS trails AS.
    assign start = as_s & (uds_s | lds_s) & window_hit(VA_i, BASE, MASK);

    assign busy = (state != ST_IDLE);

    always_ff @(posedge MCLK or negedge n_RES) begin
        if (!n_RES) begin
            state     <= ST_IDLE;
            lost      <= 1'b0;
            wait_cnt  <= 4'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 2'b00;
            mem_wdata <= '0;
            VD_o      <= '0;
            VD_d      <= 1'b0;
            n_DTACK_d <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mem_addr  <= VA_i;
                        mem_we    <= ~RW_i;
                        mem_be    <= {uds_s, lds_s};
                        mem_wdata <= VD_i;
                        mem_req   <= 1'b1;
                        lost      <= 1'b0;
                        state     <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    // The backend cannot be cancelled, so a lost strobe is only
                    // remembered here and acted on once the ack arrives.
                    if (!as_s) begin
                        lost <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wait_cnt <= WAIT_INIT;
                        if (!mem_we) begin
                            VD_o <= mem_rdata;
                        end
                        if (lost || !as_s) begin
                            state <= ST_DRAIN;
                        end else if (WAIT_INIT == 4'd0) begin
                            n_DTACK_d <= 1'b0;
                            VD_d      <= ~mem_we;
                            state     <= ST_ACK;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!as_s) begin
                        state <= ST_DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            n_DTACK_d <= 1'b0;
                            VD_d      <= ~mem_we;
                            state     <= ST_ACK;
                        end
                    end
                end

                ST_ACK: begin
                    if (!as_s) begin
                        n_DTACK_d <= 1'b1;
                        VD_d      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                ST_DRAIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
`timescale 1ns/1ps
module tb_m68k_bus_responder;
    import md_bus_pkg::*;

    // Three targets share one 68k bus: window 0x00 (W=2), 0x20 (W=0), 0x40 (W=5).
    // Region 0x60 belongs to nobody.
    localparam int N_DUT = 3;

    logic mclk = 1'b0;
    logic n_res = 1'b0;

    logic        n_as = 1'b1, n_uds = 1'b1, n_lds = 1'b1, rw = 1'b1;
    logic [22:0] va = '0;
    logic [15:0] vd = '0;

    logic [15:0] vd_o    [N_DUT];
    logic        vd_d    [N_DUT];
    logic        dtack_n [N_DUT];
    logic        req     [N_DUT];
    logic        we      [N_DUT];
    logic [22:0] addr    [N_DUT];
    logic [1:0]  be      [N_DUT];
    logic [15:0] wdata   [N_DUT];
    logic [15:0] rdata   [N_DUT];
    logic        ack     [N_DUT];
    logic        busy    [N_DUT];

    int tests    = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [15:0] vdo_model [N_DUT];

    m68k_bus_responder #(.BASE(23'h000000), .WAIT_STATES(2)) dut0 (
        .MCLK(mclk), .n_RES(n_res), .n_AS_i(n_as), .n_UDS_i(n_uds), .n_LDS_i(n_lds),
        .RW_i(rw), .VA_i(va), .VD_i(vd), .VD_o(vd_o[0]), .VD_d(vd_d[0]),
        .n_DTACK_d(dtack_n[0]), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_be(be[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ack(ack[0]),
        .busy(busy[0]));

    m68k_bus_responder #(.BASE(23'h200000), .WAIT_STATES(0)) dut1 (
        .MCLK(mclk), .n_RES(n_res), .n_AS_i(n_as), .n_UDS_i(n_uds), .n_LDS_i(n_lds),
        .RW_i(rw), .VA_i(va), .VD_i(vd), .VD_o(vd_o[1]), .VD_d(vd_d[1]),
        .n_DTACK_d(dtack_n[1]), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_be(be[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ack(ack[1]),
        .busy(busy[1]));

    m68k_bus_responder #(.BASE(23'h400000), .WAIT_STATES(5)) dut2 (
        .MCLK(mclk), .n_RES(n_res), .n_AS_i(n_as), .n_UDS_i(n_uds), .n_LDS_i(n_lds),
        .RW_i(rw), .VA_i(va), .VD_i(vd), .VD_o(vd_o[2]), .VD_d(vd_d[2]),
        .n_DTACK_d(dtack_n[2]), .mem_req(req[2]), .mem_we(we[2]), .mem_addr(addr[2]),
        .mem_be(be[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_ack(ack[2]),
        .busy(busy[2]));

    // ---------------- clock / watchdog ----------------
    always #5 mclk = ~mclk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [6:0] region_of(input int t);
        case (t)
            0:       return 7'h00;
            1:       return 7'h20;
            2:       return 7'h40;
            default: return 7'h60;
        endcase
    endfunction

    function automatic int wait_of(input int t);
        case (t)
            0:       return 2;
            1:       return 0;
            default: return 5;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("%s_dtack%0d", pfx, i), 32'(dtack_n[i]), 32'd1);
            check($sformatf("%s_vdd%0d",   pfx, i), 32'(vd_d[i]),    32'd0);
            check($sformatf("%s_vdo%0d",   pfx, i), 32'(vd_o[i]),    32'd0);
            check($sformatf("%s_req%0d",   pfx, i), 32'(req[i]),     32'd0);
            check($sformatf("%s_we%0d",    pfx, i), 32'(we[i]),      32'd0);
            check($sformatf("%s_addr%0d",  pfx, i), 32'(addr[i]),    32'd0);
            check($sformatf("%s_be%0d",    pfx, i), 32'(be[i]),      32'd0);
            check($sformatf("%s_wdata%0d", pfx, i), 32'(wdata[i]),   32'd0);
            check($sformatf("%s_busy%0d",  pfx, i), 32'(busy[i]),    32'd0);
        end
    endtask

    // One bus cycle, t = target (3 = nobody). AS goes low just before edge 1;
    // data strobes go low just before edge d+1; the backend ack is sampled at
    // edge s+1+ack_dly; AS/DS are released just before edge r.
    // rel_edge < 0 means "behave like a 68k": release after DTACK plus 'hold' cycles.
    task automatic run_txn(input int t, input bit rd, input bit u, input bit l,
                           input int d, input int ack_dly, input int rel_edge, input int hold);
        int s, a, w, r, idle_e, last_e;
        bit hit, dtack_on, tgt;
        logic [22:0] addr_v;
        logic [15:0] wd_v, rd_v, exp_vdo;
        string tn;

        hit    = (t < N_DUT);
        w      = hit ? wait_of(t) : 0;
        addr_v = {region_of(t), 16'($urandom)};
        wd_v   = 16'($urandom);
        rd_v   = 16'($urandom);
        s      = d + 3;                 // 2 sync flops, then the start edge
        a      = s + 1 + ack_dly;
        if (!hit)            r = s + 2 + hold;
        else if (rel_edge<0) r = a + w + 1 + hold;
        else                 r = rel_edge;

        // Synced AS is low at edge r+1, seen by the FSM at edge r+2.
        if (!hit)                 begin dtack_on = 0; idle_e = 0;     end
        else if (r + 2 <= a)      begin dtack_on = 0; idle_e = a + 1; end // lost in REQ
        else if (r + 2 <= a + w)  begin dtack_on = 0; idle_e = r + 3; end // lost in WAIT
        else                      begin dtack_on = 1; idle_e = r + 2; end
        last_e = ((idle_e > r + 2) ? idle_e : r + 2) + 2;
        if (hit && rd) exp_q.push_back(rd_v);

        va = addr_v; vd = wd_v; rw = rd; n_as = 1'b0;
        if (d == 0) begin n_uds = ~u; n_lds = ~l; end

        for (int e = 1; e <= last_e; e++) begin
            @(negedge mclk);
            for (int i = 0; i < N_DUT; i++) begin
                tgt = (i == t);
                tn  = $sformatf("t%0d_d%0d_e%0d", t, i, e);
                exp_vdo = (tgt && rd && e >= a) ? exp_q[0] : vdo_model[i];
                check({tn, "_req"},   32'(req[i]),  32'(tgt && e >= s && e < a));
                check({tn, "_busy"},  32'(busy[i]), 32'(tgt && e >= s && e < idle_e));
                check({tn, "_dtack"}, 32'(dtack_n[i]),
                      32'(!(tgt && dtack_on && e >= a + w && e < r + 2)));
                check({tn, "_vdd"},   32'(vd_d[i]),
                      32'(tgt && dtack_on && rd && e >= a + w && e < r + 2));
                check({tn, "_vdo"},   32'(vd_o[i]), 32'(exp_vdo));
                if (tgt && e == s) begin
                    check({tn, "_addr"},  32'(addr[i]),  32'(addr_v));
                    check({tn, "_be"},    32'(be[i]),    32'({u, l}));
                    check({tn, "_we"},    32'(we[i]),    32'(!rd));
                    check({tn, "_wdata"}, 32'(wdata[i]), 32'(wd_v));
                end
            end
            // drive for the next edge
            if (d > 0 && e == d) begin n_uds = ~u; n_lds = ~l; end
            if (e + 1 == r) begin n_as = 1'b1; n_uds = 1'b1; n_lds = 1'b1; end
            for (int i = 0; i < N_DUT; i++) begin
                if (i == t) begin
                    ack[i]   = (e + 1 == a);
                    rdata[i] = rd_v;
                end else begin
                    // Stray acks to idle targets must be ignored.
                    ack[i]   = ($urandom_range(0, 7) == 0);
                    rdata[i] = 16'($urandom);
                end
            end
        end
        for (int i = 0; i < N_DUT; i++) ack[i] = 1'b0;
        if (hit && rd) vdo_model[t] = exp_q.pop_front();
    endtask

    // Reset while target 0 sits in ACK, then a clean cycle afterwards.
    task automatic reset_in_ack();
        bit seen = 0;
        va = {region_of(0), 16'h0020}; rw = 1'b1; vd = 16'h0;
        n_as = 1'b0; n_uds = 1'b0; n_lds = 1'b0;
        rdata[0] = 16'h1234;
        for (int e = 1; e <= 30 && !seen; e++) begin
            @(negedge mclk);
            ack[0] = (e == 4);
            if (dtack_n[0] == 1'b0) seen = 1;
        end
        ack[0] = 1'b0;
        check("rst_dtack_seen", 32'(seen), 32'd1);
        #2 n_res = 1'b0;
        #1;
        check("rst_async_dtack", 32'(dtack_n[0]), 32'd1);
        check("rst_async_vdd",   32'(vd_d[0]),    32'd0);
        check("rst_async_req",   32'(req[0]),     32'd0);
        check("rst_async_busy",  32'(busy[0]),    32'd0);
        n_as = 1'b1; n_uds = 1'b1; n_lds = 1'b1;
        for (int i = 0; i < N_DUT; i++) vdo_model[i] = '0;
        @(negedge mclk);
        check_reset_values("rst_mid");
        @(negedge mclk);
        n_res = 1'b1;
        @(negedge mclk);
        run_txn(0, 1, 1, 1, 0, 1, -1, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t, d, ad, sv, rv, bsel;
        bit rd;
        for (int i = 0; i < N_DUT; i++) begin
            ack[i] = 1'b0; rdata[i] = '0; vdo_model[i] = '0;
        end
        n_res = 1'b0;
        repeat (3) @(negedge mclk);
        check_reset_values("reset");
        n_res = 1'b1;
        @(negedge mclk);

        run_txn(0, 1, 1, 1, 0, 1, -1, 0);   // word read, DTACK 7 clocks after AS
        run_txn(0, 0, 0, 1, 2, 1, -1, 1);   // lower byte write, LDS trails AS by 2
        run_txn(3, 1, 1, 1, 0, 1, -1, 2);   // nobody's window
        run_txn(2, 1, 1, 1, 0, 1, 6, 0);    // W=5, AS dropped during WAIT
        run_txn(0, 1, 1, 1, 0, 6, 4, 0);    // AS dropped while backend busy
        run_txn(1, 1, 1, 1, 0, 10, -1, 1);  // W=0, slow backend
        run_txn(1, 0, 1, 0, 1, 2, -1, 0);   // upper byte write, W=0
        reset_in_ack();

        for (int n = 0; n < 40; n++) begin
            t    = $urandom_range(0, 3);
            rd   = 1'($urandom_range(0, 1));
            bsel = $urandom_range(1, 3);
            d    = rd ? 0 : $urandom_range(0, 3);
            ad   = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0 && t < N_DUT) begin
                sv = d + 3;
                rv = $urandom_range(sv, sv + 1 + ad + wait_of(t) + 2);
            end else begin
                rv = -1;
            end
            run_txn(t, rd, bsel[1], bsel[0], d, ad, rv, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- 68000-side bus target for the Mega Drive model. It decodes a CPU or arbiter-initiated cycle (n_AS/n_UDS/n_LDS/RW) in a programmable address window.
- It forwards the cycle to a simple req/ack memory backend, inserts wait states, then drives n_DTACK and read data.
- It is the responder for the cycles the arbiter initiates on the 68k bus during Z80-to-68k window accesses. It sits alongside the cartridge/work-RAM models.

Parameters:
- BASE, 23'h000000: window base; compared against VA[23:1] after masking.
- MASK, 23'h7F0000: address bits that participate in the decode. A hit requires (VA & MASK) == (BASE & MASK).
- WAIT_STATES, 2: extra MCLK cycles between backend ack and DTACK assertion, range 0..15.

Ports:
- MCLK  in  1  system clock; all state is on the rising edge.
- n_RES  in  1  reset, asynchronous, active-low.
- n_AS_i  in  1  68k address strobe, active-low.
- n_UDS_i  in  1  upper data strobe, active-low.
- n_LDS_i  in  1  lower data strobe, active-low.
- RW_i  in  1  1 = read, 0 = write.
- VA_i  in  23  68k address bits 23:1.
- VD_i  in  16  68k data bus input.
- VD_o  out  16  read data.
- VD_d  out  1  data output enable, active-high.
- n_DTACK_d  out  1  0 = pull DTACK low (open-drain style drive).
- mem_req  out  1  backend request.
- mem_we  out  1  1 = write.
- mem_addr  out  23  latched word address.
- mem_be  out  2  byte enables; [1] = upper, [0] = lower.
- mem_wdata  out  16  latched write data.
- mem_rdata  in  16  backend read data, valid with mem_ack.
- mem_ack  in  1  backend completion, a one-cycle pulse.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (n_RES low, asynchronous):
  - FSM enters IDLE. Synchronizers are set to 1 (strobes inactive).
  - n_DTACK_d = 1, VD_d = 0, VD_o = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0, busy = 0.
  - Reset mid-cycle aborts at once; no DTACK is ever produced for an aborted cycle.
- Synchronization:
  - n_AS_i, n_UDS_i and n_LDS_i each pass through a 2-flop synchronizer, giving as_s, uds_s, lds_s (all active-high internally).
  - VA_i, VD_i and RW_i are sampled unsynchronized at the start event. They are stable by then.
- Start event: in IDLE, as_s & (uds_s | lds_s) & window hit.
  - Waiting for a data strobe covers 68k writes, where DS trails AS.
- FSM states: IDLE, REQ, WAIT, ACK, DRAIN.
- IDLE → REQ on the start event. In the same edge:
  - mem_addr ← VA_i, mem_we ← ~RW_i, mem_be ← {uds_s, lds_s}, mem_wdata ← VD_i, mem_req ← 1.
  - A miss (as_s without a hit) stays in IDLE with no response, so another target answers.
- REQ:
  - mem_req is held high until mem_ack.
  - On mem_ack, mem_req ← 0. For reads, VD_o ← mem_rdata.
  - Counter ← WAIT_STATES. Next state is WAIT, or ACK directly if WAIT_STATES == 0.
- WAIT: the 4-bit counter decrements each cycle; the FSM moves to ACK when the counter reaches 1→0.
- ACK:
  - n_DTACK_d = 0. VD_d = RW latched (reads only).
  - Remains until as_s == 0, then moves to IDLE, deasserting n_DTACK_d and VD_d in that same edge.
- Early strobe loss (as_s drops while in REQ or WAIT):
  - The backend cannot be aborted.
  - In REQ: mem_req stays high until mem_ack, then the FSM goes to DRAIN.
  - In WAIT: go to DRAIN at once.
  - DRAIN → IDLE next cycle. DTACK is never asserted and the read data is discarded (VD_o is still updated).
- Latency, read hit with the backend acking on the cycle after req and WAIT_STATES = W:
  - n_DTACK_d falls 2 (sync) + 1 (start) + 1 (ack) + W + 1 MCLK after n_AS_i falls.
- Back-to-back cycles: a new start is accepted only from IDLE, so at least one IDLE cycle occurs after AS negation.
- mem_ack outside REQ is ignored.
- busy = (state != IDLE).

Decomposition:
- Shared package md_bus_pkg holds:
  - the state enum for IDLE/REQ/WAIT/ACK/DRAIN;
  - the width constants VA_W = 23 and VD_W = 16;
  - the byte-enable encodings BE_UPPER = 2'b10, BE_LOWER = 2'b01, BE_WORD = 2'b11.
- One sub-module, md_sync2: a 2-flop synchronizer with reset value 1, instantiated 3 times.

Test Plan:
- Word read hit: BASE = 0, VA = 23'h000010, RW = 1, UDS = LDS = 0, backend acks 1 cycle after req with 16'hBEEF, W = 2.
  - Required: mem_be = 2'b11, mem_we = 0; n_DTACK_d low exactly 7 MCLK after n_AS_i falls; VD_o = 16'hBEEF with VD_d = 1; both released 1 cycle after synced AS negation.
- Byte write, lower: RW = 0, VD = 16'h12A5, LDS asserted 2 cycles after AS, UDS idle.
  - Required: start waits for LDS; mem_be = 2'b01, mem_we = 1, mem_wdata = 16'h12A5; VD_d stays 0 throughout.
- Window miss: BASE = 23'h200000 with MASK default, VA = 23'h000010.
  - Required: mem_req never rises, n_DTACK_d stays 1, busy stays 0.
- Early AS negation: release n_AS_i during WAIT with W = 5.
  - Required: FSM goes WAIT → DRAIN → IDLE, no DTACK pulse, busy = 0 within 2 cycles of synced negation.
- Slow backend with W = 0: mem_ack delayed 10 cycles.
  - Required: mem_req held high for all 10 cycles; DTACK asserted the cycle after ack.
- Asynchronous reset asserted in ACK.
  - Required: n_DTACK_d = 1, VD_d = 0, mem_req = 0 immediately without waiting for a clock; the next cycle after reset release starts cleanly.
